dmem_responder: RTL and testbench

//   Memory-side responder for the core's data-memory port. Accepts one

---
 rtl/dmem_responder_if.sv | 45 ++++
 rtl/dmem_responder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the core's data-memory port (master) and
//   the memory-side responder (slave).
//
//   Request channel  (master -> slave, valid/ready):
//     req_valid  request present
//     req_ready  slave can accept (slave -> master)
//     req_write  1 = store, 0 = load
//     req_addr   byte address
//     req_wdata  store data, LSB-aligned
//     req_funct3 RV32I size/sign code
//   Response channel (slave -> master, valid/ready):
//     rsp_valid  response present
//     rsp_ready  master takes the response (master -> slave)
//     rsp_rdata  extended load result, 0 for stores and errors
//     rsp_err    misaligned access or illegal funct3
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the core's data-memory port. Accepts one
//   load/store at a time, performs it against a local word array after a
//   fixed latency and returns the (extended) load data on a response channel.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low (0 = in reset)
//     bus    dmem_responder_if.slave: request channel (req_*) in,
//            response channel (rsp_*) out
//
//   Parameters:
//     DATA_W      data width, must be 32
//     DM_ADDRESS  byte-address width; array holds 2**(DM_ADDRESS-2) words
//     LATENCY     edges from accept (inclusive) to the edge that raises
//                 rsp_valid; legal 1..15
//
//   The array is never cleared by reset. The access (store write / load
//   sample) happens on the single edge that moves the FSM into RESP, so a
//   later transaction always observes an earlier store.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);
    localparam int IDX_W = DM_ADDRESS - 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Control state (reset)
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Latched request (no reset: only meaningful once a request is accepted)
    logic                  write_q, write_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;

    // Data array
    logic [DATA_W-1:0] mem_q [WORDS];

    // Access-path signals
    logic                  acc_fire;
    logic                  acc_write;
    logic [DM_ADDRESS-1:0] acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [2:0]            acc_funct3;
    logic [IDX_W-1:0]      acc_idx;
    logic [1:0]            acc_lane;
    logic                  acc_err;
    logic [DATA_W-1:0]     acc_word;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;

    // -------------------------------------------------------------------------
    // Access helpers
    // -------------------------------------------------------------------------

    // Misalignment or an funct3 code that is illegal for the access direction.
    function automatic logic access_err(input logic       wr,
                                        input logic [1:0] lane,
                                        input logic [2:0] f3);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = lane[0];
            3'b010:  err = |lane;
            3'b100:  err = wr;              // LBU has no store counterpart
            3'b101:  err = wr | lane[0];    // LHU has no store counterpart
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Select the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        lane,
                                                      input logic [2:0]        f3);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[DATA_W-1:16] : word[15:0];
        case (f3)
            3'b000:  r = {{(DATA_W-8){b[7]}}, b};
            3'b100:  r = {{(DATA_W-8){1'b0}}, b};
            3'b001:  r = {{(DATA_W-16){h[15]}}, h};
            3'b101:  r = {{(DATA_W-16){1'b0}}, h};
            3'b010:  r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Merge store data into the old word; lanes outside the access keep
    // their previous contents. Store data is replicated across lanes so the
    // byte-enable alone selects what lands where.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [1:0]        lane,
                                                      input logic [2:0]        f3);
        logic [3:0]        be;
        logic [DATA_W-1:0] src;
        logic [DATA_W-1:0] r;
        case (f3)
            3'b000: begin
                be  = 4'b0001 << lane;
                src = {4{wdata[7:0]}};
            end
            3'b001: begin
                be  = lane[1] ? 4'b1100 : 4'b0011;
                src = {2{wdata[15:0]}};
            end
            default: begin
                be  = 4'b1111;
                src = wdata;
            end
        endcase
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = src[8*i +: 8];
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

    // -------------------------------------------------------------------------
    // Access path
    // -------------------------------------------------------------------------
    always_comb begin
        // With LATENCY=1 the access happens on the accept edge itself, before
        // the request has been latched, so IDLE uses the live request fields.
        if (state_q == IDLE) begin
            acc_write  = bus.req_write;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
            acc_funct3 = bus.req_funct3;
        end else begin
            acc_write  = write_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_funct3 = funct3_q;
        end
        acc_idx  = acc_addr[DM_ADDRESS-1:2];
        acc_lane = acc_addr[1:0];
        acc_err  = access_err(acc_write, acc_lane, acc_funct3);
        acc_word = mem_q[acc_idx];

        // The edge that enters RESP; gated by reset so nothing is written
        // while the block is held in reset.
        acc_fire = reset &&
                   (((state_q == IDLE) && bus.req_valid && (LATENCY == 1)) ||
                    ((state_q == WAIT) && (cnt_q == CNT_W'(1))));

        mem_we    = acc_fire && acc_write && !acc_err;
        mem_wdata = store_merge(acc_word, acc_wdata, acc_lane, acc_funct3);
    end

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if ((state_q == IDLE) && bus.req_valid) begin
            write_d  = bus.req_write;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
            funct3_d = bus.req_funct3;
        end

        // Response registers are loaded once and then held through RESP.
        if (acc_fire) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_write || acc_err) ? '0
                        : load_extend(acc_word, acc_lane, acc_funct3);
        end
    end

    always_ff @(posedge clk) begin
        write_q  <= write_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        funct3_q <= funct3_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Directed bench for dmem_responder: three instances with LATENCY 2, 3 and 1.
module tb_dmem_responder;

    localparam int LAT_T [3] = '{2, 3, 1};

    logic clk;
    int   vectors;
    int   miscompares;

    logic [2:0]       rst_n_t;
    logic [2:0]       req_valid_t;
    logic [2:0]       req_write_t;
    logic [2:0][8:0]  req_addr_t;
    logic [2:0][31:0] req_wdata_t;
    logic [2:0][2:0]  req_funct3_t;
    logic [2:0]       rsp_ready_t;

    logic [2:0]       req_ready_o;
    logic [2:0]       rsp_valid_o;
    logic [2:0][31:0] rsp_rdata_o;
    logic [2:0]       rsp_err_o;

    dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req_valid  = req_valid_t[g];
        assign bus[g].req_write  = req_write_t[g];
        assign bus[g].req_addr   = req_addr_t[g];
        assign bus[g].req_wdata  = req_wdata_t[g];
        assign bus[g].req_funct3 = req_funct3_t[g];
        assign bus[g].rsp_ready  = rsp_ready_t[g];
        assign req_ready_o[g]    = bus[g].req_ready;
        assign rsp_valid_o[g]    = bus[g].rsp_valid;
        assign rsp_rdata_o[g]    = bus[g].rsp_rdata;
        assign rsp_err_o[g]      = bus[g].rsp_err;

        dmem_responder #(
            .DATA_W    (32),
            .DM_ADDRESS(9),
            .LATENCY   (LAT_T[g])
        ) u_dut (
            .clk  (clk),
            .reset(rst_n_t[g]),
            .bus  (bus[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One complete transaction on instance d. hold>0 keeps rsp_ready low for
    // that many cycles in RESP while a new request is held on req_valid.
    task automatic txn(input int d, input logic wr, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic [31:0] want_rd, input logic want_err,
                       input int hold, input string tag);
        int edges;
        @(negedge clk);
        chk({tag, ".idle_rdy"}, 32'(req_ready_o[d]), 32'd1);
        req_valid_t[d]  = 1'b1;
        req_write_t[d]  = wr;
        req_addr_t[d]   = addr;
        req_wdata_t[d]  = wd;
        req_funct3_t[d] = f3;
        rsp_ready_t[d]  = (hold == 0);
        @(posedge clk);
        #1;
        edges = 1;
        if (hold == 0) req_valid_t[d] = 1'b0;
        while (rsp_valid_o[d] !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, ".lat"}, 32'(edges), 32'(LAT_T[d]));
        chk({tag, ".rdata"}, rsp_rdata_o[d], want_rd);
        chk({tag, ".err"}, 32'(rsp_err_o[d]), 32'(want_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_vld"}, 32'(rsp_valid_o[d]), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata_o[d], want_rd);
            chk({tag, ".hold_rdy"}, 32'(req_ready_o[d]), 32'd0);
        end
        rsp_ready_t[d] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".done_vld"}, 32'(rsp_valid_o[d]), 32'd0);
        chk({tag, ".done_rdy"}, 32'(req_ready_o[d]), 32'd1);
        req_valid_t[d] = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n_t      = 3'b000;
        req_valid_t  = '0;
        req_write_t  = '0;
        req_addr_t   = '0;
        req_wdata_t  = '0;
        req_funct3_t = '0;
        rsp_ready_t  = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst.req_ready", 32'(req_ready_o[g]), 32'd1);
            chk("rst.rsp_valid", 32'(rsp_valid_o[g]), 32'd0);
            chk("rst.rsp_rdata", rsp_rdata_o[g], 32'd0);
            chk("rst.rsp_err", 32'(rsp_err_o[g]), 32'd0);
        end
        @(negedge clk);
        rst_n_t = 3'b111;

        // LATENCY=2 instance: word store/load and sub-word extension
        txn(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0, 0, "sw010");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0, "lw010");
        txn(0, 1'b0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 0, "lb013");
        txn(0, 1'b0, 9'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0, 0, "lbu013");
        txn(0, 1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 0, "lh012");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, 0, "lhu010");
        txn(0, 1'b1, 9'h011, 32'h00000055, 3'b000, 32'h00000000, 1'b0, 0, "sb011");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 0, "lw010b");

        // Errors: misaligned and illegal funct3; array must be untouched
        txn(0, 1'b0, 9'h012, 32'h0,        3'b010, 32'h00000000, 1'b1, 0, "lw012_mis");
        txn(0, 1'b1, 9'h011, 32'h00001234, 3'b001, 32'h00000000, 1'b1, 0, "sh011_mis");
        txn(0, 1'b1, 9'h010, 32'h12345678, 3'b100, 32'h00000000, 1'b1, 0, "st_badf3");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b011, 32'h00000000, 1'b1, 0, "ld_badf3");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0, 0, "lw010c");

        // Halfword store into upper half, positive-byte sign extension
        txn(0, 1'b1, 9'h012, 32'hAAAACAFE, 3'b001, 32'h00000000, 1'b0, 0, "sh012");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hCAFE55EF, 1'b0, 0, "lw010d");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b000, 32'hFFFFFFEF, 1'b0, 0, "lb010");
        txn(0, 1'b0, 9'h011, 32'h0,        3'b000, 32'h00000055, 1'b0, 0, "lb011");
        txn(0, 1'b0, 9'h010, 32'h0,        3'b001, 32'h000055EF, 1'b0, 0, "lh010");

        // Back-pressure: rsp_ready low for 5 cycles in RESP
        txn(0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hCAFE55EF, 1'b0, 5, "hold5");

        // LATENCY=1 instance
        txn(2, 1'b1, 9'h004, 32'h01234567, 3'b010, 32'h00000000, 1'b0, 0, "l1_sw");
        txn(2, 1'b0, 9'h007, 32'h0,        3'b000, 32'h00000001, 1'b0, 0, "l1_lb");
        txn(2, 1'b0, 9'h006, 32'h0,        3'b101, 32'h00000123, 1'b0, 0, "l1_lhu");
        txn(2, 1'b0, 9'h004, 32'h0,        3'b010, 32'h01234567, 1'b0, 0, "l1_lw");

        // LATENCY=3 instance: reset during WAIT drops the store
        txn(1, 1'b1, 9'h020, 32'h11112222, 3'b010, 32'h00000000, 1'b0, 0, "l3_sw_old");
        @(negedge clk);
        req_valid_t[1]  = 1'b1;
        req_write_t[1]  = 1'b1;
        req_addr_t[1]   = 9'h020;
        req_wdata_t[1]  = 32'h99998888;
        req_funct3_t[1] = 3'b010;
        rsp_ready_t[1]  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_t[1] = 1'b0;
        chk("l3_wait.req_ready", 32'(req_ready_o[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_n_t[1] = 1'b0;
        #1;
        chk("l3_rstwait.req_ready", 32'(req_ready_o[1]), 32'd1);
        chk("l3_rstwait.rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n_t[1] = 1'b1;
        txn(1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h11112222, 1'b0, 0, "l3_lw_old");

        // LATENCY=3: reset while holding a load response clears outputs at once
        @(negedge clk);
        req_valid_t[1]  = 1'b1;
        req_write_t[1]  = 1'b0;
        req_addr_t[1]   = 9'h020;
        req_funct3_t[1] = 3'b010;
        rsp_ready_t[1]  = 1'b0;
        @(posedge clk);
        #1;
        req_valid_t[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("l3_resp.rsp_valid", 32'(rsp_valid_o[1]), 32'd1);
        chk("l3_resp.rsp_rdata", rsp_rdata_o[1], 32'h11112222);
        rst_n_t[1] = 1'b0;
        #1;
        chk("l3_rstresp.rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
        chk("l3_rstresp.rsp_rdata", rsp_rdata_o[1], 32'd0);
        chk("l3_rstresp.req_ready", 32'(req_ready_o[1]), 32'd1);
        @(negedge clk);
        rst_n_t[1]     = 1'b1;
        rsp_ready_t[1] = 1'b1;
        txn(1, 1'b0, 9'h022, 32'h0, 3'b101, 32'h00001111, 1'b0, 0, "l3_lhu");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
